reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the MIPS datapath, successor to the fixed 32x32 file.
- Registered (1-cycle) synchronous reads with write-to-read bypass.
- Byte-enabled writes and an optional hardwired zero register.
- Hardware init sweep that zeroes every entry after reset or on request, replacing simulation-only initialisation.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
DEPTH, 32, number of registers; must be at least 2.
ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
NUM_RD, 2, number of independent read ports (1..4).
ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  single-cycle pulse; restarts the init sweep
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit i covers byte i
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is slice k
rd_data  out  NUM_RD*DATA_W  packed registered read data
init_busy  out  1  high while the sweep runs
wr_err  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset: rst_n low asynchronously forces FSM=INIT, sweep counter=0, rd_data=0, init_busy=1, wr_err=0. The storage array itself is not reset.
- FSM states:
  - INIT: each cycle writes 0 to entry[cnt], then cnt++. At cnt==DEPTH-1, the zero write completes and the next state is RUN. Duration is exactly DEPTH cycles after rst_n deasserts.
  - RUN: normal operation. clr_req=1 goes to INIT with cnt=0 on the next edge.
  - clr_req is ignored while already in INIT; the sweep does not restart.
- init_busy = (state==INIT), registered. The first cycle with init_busy=0 accepts writes.
- Write, in RUN only: on a clk edge with wr_en=1, for each i with wr_be[i]=1, entry[wr_addr] byte i <= wr_data byte i. Bytes with wr_be[i]=0 keep their value. wr_be=0 writes nothing and is not an error.
- Dropped writes: wr_en=1 while in INIT, or wr_addr>=DEPTH (non-power-of-2 DEPTH). The write is ignored and wr_err=1 on the following cycle.
- ZERO_REG=1 and wr_addr==0: the write is silently discarded, with no wr_err.
- Same-edge wr_en and clr_req in RUN: the write is performed, then the sweep starts next cycle and clears it.
- Read: rd_data[k] is registered, with latency 1. Value = entry[rd_addr[k]] as of the sampling edge.
- Bypass: if a valid RUN write targets rd_addr[k] on the same edge, each enabled byte returns wr_data and each other byte returns the old entry value (write-first).
- Read forced to 0 when any of these holds:
  - state==INIT at the sampling edge;
  - ZERO_REG=1 and rd_addr[k]==0;
  - rd_addr[k]>=DEPTH.
- All read ports are independent. Identical addresses on multiple ports return identical data.
- Mid-sweep reset: re-asserting rst_n restarts the sweep from cnt=0.
- Widths: cnt is ADDR_W bits and the comparison against DEPTH-1 is exact, so there is no wrap past DEPTH.

Decomposition:
- Package mips_rf_pkg:
  - FSM state typedef rf_state_t {RF_INIT, RF_RUN};
  - default constants RF_DATA_W=32, RF_DEPTH=32;
  - function rf_merge_be(old, new, be) for the byte merge, used by both the write path and the bypass.
- One natural sub-module: rf_read_port, one registered read mux with bypass and zero forcing, instantiated NUM_RD times in a generate loop.
- The FSM, sweep counter and array stay in the top level.

Test Plan:
1. Reset then release, DEPTH=32: init_busy stays high exactly 32 cycles. A write attempted at cycle 5 gives wr_err pulse and no effect. After the sweep, read of reg 7 returns 0.
2. RUN: write reg 3 = 0xDEADBEEF, wr_be=4'hF, then reg 3 = 0x000000AA with wr_be=4'h1. Next-cycle read of port 0 at reg 3 returns 0xDEADBEAA.
3. Same-edge write reg 9 = 0x12345678 (be=4'hC) while ports 0 and 1 both read reg 9, old value 0x11111111. Both return 0x12341111 one cycle later.
4. ZERO_REG=1: write reg 0 = 0xFFFFFFFF. Read reg 0 returns 0 and wr_err stays 0. Repeat with ZERO_REG=0: reads 0xFFFFFFFF.
5. Fill regs 1..31 with non-zero values, pulse clr_req together with a write to reg 4 = 0x5. init_busy rises next cycle for 32 cycles, and all regs read 0 afterwards.
6. rst_n asserted at sweep cycle 10, released 3 cycles later: the sweep restarts and takes a full 32 cycles. Also run DEPTH=24, NUM_RD=3: wr_addr=30 gives wr_err and reading addr 30 returns 0.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: shared state type, default sizes and byte-merge helper for reg_file_mp
package mips_rf_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_MAX_W  = 256;
    localparam int RF_MAX_BE = RF_MAX_W / 8;

    // Works at the widest supported word; callers size-cast operands in and the result out.
    function automatic logic [RF_MAX_W-1:0] rf_merge_be(
        input logic [RF_MAX_W-1:0]  old_w,
        input logic [RF_MAX_W-1:0]  new_w,
        input logic [RF_MAX_BE-1:0] be
    );
        logic [RF_MAX_W-1:0] r;
        for (int i = 0; i < RF_MAX_BE; i++)
            r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/reg_file_mp_rd_port.sv
// rf_read_port: one registered read port with write-first byte bypass and zero forcing
module rf_read_port
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   entry,
    input  logic                wr_ok,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] rd_d, rd_q;
    logic              zero, hit;

    always_comb begin
        zero = !run || (ZERO_REG && rd_addr == '0) || 32'(rd_addr) >= DEPTH;
        hit  = wr_ok && wr_addr == rd_addr;
        rd_d = zero ? '0
             : hit  ? DATA_W'(rf_merge_be(RF_MAX_W'(entry), RF_MAX_W'(wr_data), RF_MAX_BE'(wr_be)))
             :        entry;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;

    assign rd_data = rd_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with byte-enabled writes, bypass and a hardware clear sweep
module reg_file_mp
    import mips_rf_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_RD   = 2,
    parameter  bit ZERO_REG = 1'b1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     init_busy,
    output logic                     wr_err
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d, err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              run, in_rng, wr_ok;

    always_comb begin
        run     = state_q == RF_RUN;
        in_rng  = 32'(wr_addr) < DEPTH;
        wr_ok   = run && wr_en && in_rng && !(ZERO_REG && wr_addr == '0);
        err_d   = wr_en && (!run || !in_rng);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RF_RUN;
                cnt_d   = '0;
            end
        end else if (clr_req) begin
            state_d = RF_INIT;
            cnt_d   = '0;
        end
        busy_d   = state_d == RF_INIT;
        // The sweep owns the single write port while it runs.
        mem_we   = !run || wr_ok;
        mem_addr = run ? wr_addr : cnt_q;
        mem_wd   = run ? DATA_W'(rf_merge_be(RF_MAX_W'(mem_q[wr_addr]), RF_MAX_W'(wr_data), RF_MAX_BE'(wr_be)))
                       : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end

    always_ff @(posedge clk)
        if (mem_we) mem_q[mem_addr] <= mem_wd;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .rd_addr(rd_addr[k*ADDR_W +: ADDR_W]),
            .entry  (mem_q[rd_addr[k*ADDR_W +: ADDR_W]]),
            .wr_ok  (wr_ok),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .wr_be  (wr_be),
            .rd_data(rd_data[k*DATA_W +: DATA_W])
        );
    end

    assign init_busy = busy_q;
    assign wr_err    = err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench over three configurations (default, ZERO_REG=0, DEPTH=24/NUM_RD=3)
module tb_reg_file_mp;

    logic        clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0, wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic [9:0]  rd_a = '0;
    logic [14:0] rd_a2 = '0;
    logic [63:0] rd_d0, rd_d1;
    logic [95:0] rd_d2;
    logic        busy0, busy1, busy2, err0, err1, err2;
    int          n_chk = 0, n_pass = 0;
    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    reg_file_mp u0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_a), .rd_data(rd_d0),
        .init_busy(busy0), .wr_err(err0)
    );

    reg_file_mp #(.ZERO_REG(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_a), .rd_data(rd_d1),
        .init_busy(busy1), .wr_err(err1)
    );

    reg_file_mp #(.DEPTH(24), .NUM_RD(3)) u2 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_a2), .rd_data(rd_d2),
        .init_busy(busy2), .wr_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] obs(input int s);
        case (s)
            0:          return rd_d0[31:0];
            1:          return rd_d0[63:32];
            10:         return rd_d1[31:0];
            11:         return rd_d1[63:32];
            20, 21, 22: return rd_d2[(s-20)*32 +: 32];
            30:         return {31'b0, err0};
            31:         return {31'b0, err1};
            32:         return {31'b0, err2};
            41:         return {31'b0, busy1};
            default:    return 'x;
        endcase
    endfunction

    task automatic push(input int s, input logic [31:0] e, input string tag);
        sel_q.push_back(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        int          s;
        logic [31:0] e;
        string       t;
        @(posedge clk);
        @(negedge clk);
        while (sel_q.size() > 0) begin
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, obs(s), e);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic idle();
        wr_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_a = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int n, n2;
        repeat (3) @(negedge clk);
        chk("rst_rd0", obs(0), 32'h0);
        chk("rst_rd1", obs(1), 32'h0);
        chk("rst_busy", {31'b0, busy0}, 32'h1);
        chk("rst_err", obs(30), 32'h0);

        // sweep after reset release, with a write attempted mid-sweep
        rst_n = 1'b1;
        n = 0; n2 = 0;
        while (busy0 && n < 100) begin
            n2 += int'(busy2);
            n++;
            idle();
            if (n == 5) begin
                wr(7, 32'hFFFFFFFF, 4'hF);
                push(30, 32'h1, "init_wr_err");
                push(32, 32'h1, "init_wr_err24");
            end else if (n == 6) push(30, 32'h0, "init_err_pulse_end");
            tick();
        end
        chk("init_len", n, 32);
        chk("init_len24", n2, 24);
        idle(); rd(7, 7);
        push(0, 32'h0, "post_init_r7_p0");
        push(1, 32'h0, "post_init_r7_p1");
        push(10, 32'h0, "post_init_r7_nozr");
        push(41, 32'h0, "post_init_busy_nozr");
        tick();

        // byte-enabled merge
        wr(3, 32'hDEADBEEF, 4'hF); tick();
        wr(3, 32'h000000AA, 4'h1); tick();
        idle(); rd(3, 0);
        push(0, 32'hDEADBEAA, "be_merge");
        push(10, 32'hDEADBEAA, "be_merge_nozr");
        push(1, 32'h0, "zero_reg_rd");
        tick();

        // same-edge bypass on two ports
        wr(9, 32'h11111111, 4'hF); tick();
        wr(9, 32'h12345678, 4'hC); rd(9, 9);
        push(0, 32'h12341111, "bypass_p0");
        push(1, 32'h12341111, "bypass_p1");
        tick();
        idle();
        push(0, 32'h12341111, "stored_p0");
        push(1, 32'h12341111, "stored_p1");
        tick();

        // zero register handling in both configurations
        wr(0, 32'hFFFFFFFF, 4'hF);
        push(30, 32'h0, "zr_no_err");
        push(31, 32'h0, "nozr_no_err");
        tick();
        idle(); rd(0, 0);
        push(0, 32'h0, "zr_read");
        push(10, 32'hFFFFFFFF, "nozr_read");
        tick();

        // wr_be=0 writes nothing and is not an error
        wr(5, 32'hAAAA5555, 4'hF); tick();
        wr(5, 32'h12345678, 4'h0);
        push(30, 32'h0, "be0_no_err");
        tick();
        idle(); rd(5, 5);
        push(0, 32'hAAAA5555, "be0_keep");
        tick();

        // fill, then clear with a same-edge write
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101, 4'hF);
            tick();
        end
        wr(4, 32'h5, 4'hF); clr_req = 1'b1; rd(4, 31);
        push(0, 32'h5, "clr_same_edge_byp");
        push(1, 32'h1F1F1F1F, "fill_r31");
        tick();
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            idle();
            clr_req = (n == 10);
            tick();
        end
        chk("clr_len", n, 32);
        idle();
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            push(0, 32'h0, $sformatf("clr_rd_%0d", i));
            push(1, 32'h0, $sformatf("clr_rd_%0d", 31 - i));
            push(10, 32'h0, $sformatf("clr_rd_nozr_%0d", i));
            tick();
        end

        // reset re-asserted mid-sweep restarts it from zero
        clr_req = 1'b1; tick();
        idle();
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy0}, 32'h1);
        repeat (3) tick();
        rst_n = 1'b1;
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            tick();
        end
        chk("restart_len", n, 32);

        // out-of-range address on the 24-entry file
        wr(30, 32'hCAFEF00D, 4'hF); rd_a2 = {5'd23, 5'd30, 5'd30};
        push(32, 32'h1, "oor_wr_err");
        push(30, 32'h0, "inrange_no_err");
        push(20, 32'h0, "oor_bypass");
        tick();
        wr(23, 32'hCAFEF00D, 4'hF);
        push(32, 32'h0, "oor_err_pulse_end");
        push(22, 32'hCAFEF00D, "d24_byp_r23");
        tick();
        idle();
        push(22, 32'hCAFEF00D, "d24_r23");
        push(21, 32'h0, "oor_rd");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
